flip_row_feeder: RTL
====================

Name: flip_row_feeder

Overview:
- Upstream feeder for update_dot_products.
- Takes a spin-flip mask and the new spin values for one annealing step, then fetches the J-matrix rows of the flipped spins from coupling memory.
- Each cycle it issues up to NUM_ROWS_PER_CLK rows, with a per-lane valid mask and sigma bits, aligned for direct connection to j_rows / j_rows_valid / sigma_bits.
- Signals completion once every fetched row has left its output register.

Parameters:
- NUM_ROWS_PER_CLK, 4, rows issued per cycle (lanes); must match update_dot_products.
- VECTOR_SIZE, 8, number of spins; also the row length and the row count of J.
- DATA_WIDTH, 4, signed J element width.
- MEM_LATENCY, 2, fixed read latency of the coupling memory in cycles (≥1).
- IDX_WIDTH, $clog2(VECTOR_SIZE), row-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a step. Honoured only in IDLE.
- abort  in  1  synchronous abandon of the current step.
- flip_mask  in  VECTOR_SIZE  bit i=1 means spin i flips this step; sampled on start.
- sigma_new  in  VECTOR_SIZE  new spin values (1=+1, 0=-1); sampled on start.
- mem_rd_en  out  NUM_ROWS_PER_CLK  per-lane read strobe.
- mem_rd_addr  out  NUM_ROWS_PER_CLK x IDX_WIDTH  per-lane row index.
- mem_rd_data  in  NUM_ROWS_PER_CLK x VECTOR_SIZE x DATA_WIDTH signed  row data, valid MEM_LATENCY cycles after mem_rd_en.
- j_rows  out  NUM_ROWS_PER_CLK x VECTOR_SIZE x DATA_WIDTH signed  registered rows to the downstream stage.
- j_rows_valid  out  NUM_ROWS_PER_CLK  lane valid mask.
- sigma_bits  out  NUM_ROWS_PER_CLK  new spin value per lane.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a step completes.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal mask and sigma registers 0.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE: on start, latch flip_mask into rem_mask and sigma_new into sig_reg. Go to SCAN if the mask is non-zero, else DRAIN.
  - SCAN: each cycle, select the k = min(popcount(rem_mask), NUM_ROWS_PER_CLK) lowest set bits, in ascending index order. Lane r gets the r-th selected index. Assert mem_rd_en[r] with that address for r<k; lanes r≥k stay low. Clear the selected bits. When rem_mask becomes 0, go to DRAIN.
  - DRAIN: count MEM_LATENCY+1 cycles, then pulse done and return to IDLE.
- Lane metadata: each lane's enable and sigma (sig_reg[index]) travel through a MEM_LATENCY-deep shift pipeline beside the memory.
- Output timing: a read issued in cycle t produces, at cycle t+MEM_LATENCY+1:
  - j_rows[r] = mem_rd_data[r], registered;
  - j_rows_valid[r] = the lane's piped enable;
  - sigma_bits[r] = the lane's piped sigma.
- Invalid lanes: j_rows zeroed, sigma_bits 0.
- Timing relations:
  - Total rows issued = popcount(flip_mask).
  - Number of SCAN cycles = ceil(popcount / NUM_ROWS_PER_CLK).
  - done asserts the cycle after the last valid output beat.
  - Empty mask: no valid beats; done arrives MEM_LATENCY+2 cycles after start.
- start while busy: ignored, with no effect on rem_mask.
- start together with abort in IDLE: abort wins and the start is dropped.
- abort in SCAN/DRAIN: next cycle FSM is IDLE, rem_mask cleared, all piped enables cleared, so j_rows_valid = 0 from the next cycle. No done pulse.
- rst mid-step: same as abort, but takes effect immediately and asynchronously.
- No backpressure: the downstream accepts one beat per cycle.

Optional Feature:
- Macro FLIP_ROW_FEEDER_STATS_EN.
- When defined:
  - Adds output stat_rows (32 bit): total valid lanes emitted.
  - Adds output stat_steps (32 bit): total done pulses.
  - Both reset to 0, saturate at all-ones, and are unaffected by abort.
- When undefined: neither port nor the counters exist. Functional behaviour is identical in both builds.

Decomposition:
- Shared package flip_row_feeder_pkg holds:
  - the FSM state enum (IDLE/SCAN/DRAIN);
  - the row-index typedef;
  - a lane-metadata struct {en, sigma}.
- Sub-module lowest_n_select: combinational, returns N one-hot-encoded lowest set bits of a mask plus a per-lane found flag.

Test Plan (defaults, memory model returns J[i][c]=((i+c)%8)-4, MEM_LATENCY=2):
- flip_mask=8'b0000_0001, sigma_new=8'hFF -> one beat at start+4 with j_rows_valid=4'b0001, lane0 row 0, sigma_bits[0]=1; done at start+5.
- flip_mask=8'hFF, sigma_new=8'hAA -> two beats: rows 0-3 then 4-7, valid 4'b1111 each; sigma_bits 4'b1010 then 4'b1010; done one cycle after the second beat.
- flip_mask=8'b1010_0100 -> one beat: lanes 0..2 carry rows 2, 5, 7; valid=4'b0111; lane 3 data is 0.
- flip_mask=0 -> no valid beats; done at start+4; busy high for cycles start+1..start+4.
- flip_mask=8'hFF, abort one cycle into SCAN -> no done; j_rows_valid=0 from the cycle after abort; a new start is accepted the cycle after that.
- End-to-end: chain with update_dot_products (PIPED=1, reset_values=0), random masks -> accumulated_sums match the reference model, computed as accumulated_sums[c] += 2*J[i][c]*(sigma?+1:-1) over all flipped rows i.

Source files
------------

// File: rtl/flip_row_feeder_pkg.sv
// Shared types for flip_row_feeder: FSM states, row index and per-lane metadata.
package flip_row_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_IDX_W = 16;
    typedef logic [MAX_IDX_W-1:0] row_idx_t;

    typedef struct packed {
        logic en;
        logic sigma;
    } lane_meta_t;

endpackage

// File: rtl/flip_row_feeder_select.sv
// lowest_n_select: picks the N lowest set bits of a mask as one-hot vectors, in ascending order.
module lowest_n_select #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [W-1:0]        mask,
    output logic [N-1:0][W-1:0] sel,
    output logic [N-1:0]        found
);

    logic [W-1:0] rest;

    always_comb begin
        rest  = mask;
        sel   = '0;
        found = '0;
        for (int r = 0; r < N; r++) begin
            // two's-complement trick isolates the lowest remaining set bit
            sel[r]   = rest & (~rest + W'(1));
            found[r] = |rest;
            rest     = rest & ~sel[r];
        end
    end

endmodule

// File: rtl/flip_row_feeder.sv
// Fetches J rows of flipped spins, up to NUM_ROWS_PER_CLK per cycle, and aligns lane metadata.
// Optional FLIP_ROW_FEEDER_STATS_EN adds saturating row/step counters.
module flip_row_feeder
    import flip_row_feeder_pkg::*;
#(
    parameter int NUM_ROWS_PER_CLK = 4,
    parameter int VECTOR_SIZE      = 8,
    parameter int DATA_WIDTH       = 4,
    parameter int MEM_LATENCY      = 2,
    parameter int IDX_WIDTH        = $clog2(VECTOR_SIZE)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic [VECTOR_SIZE-1:0] flip_mask,
    input  logic [VECTOR_SIZE-1:0] sigma_new,
    output logic [NUM_ROWS_PER_CLK-1:0] mem_rd_en,
    output logic [NUM_ROWS_PER_CLK-1:0][IDX_WIDTH-1:0] mem_rd_addr,
    input  logic signed [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mem_rd_data,
    output logic signed [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_rows,
    output logic [NUM_ROWS_PER_CLK-1:0] j_rows_valid,
    output logic [NUM_ROWS_PER_CLK-1:0] sigma_bits,
    output logic busy,
`ifdef FLIP_ROW_FEEDER_STATS_EN
    output logic [31:0] stat_rows,
    output logic [31:0] stat_steps,
`endif
    output logic done
);

    localparam int N  = NUM_ROWS_PER_CLK;
    localparam int CW = $clog2(MEM_LATENCY + 2) + 1;

    state_t                 state_q, state_d;
    logic [VECTOR_SIZE-1:0] rem_mask_q, rem_mask_d;
    logic [VECTOR_SIZE-1:0] sig_reg_q, sig_reg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;

    lane_meta_t [MEM_LATENCY-1:0][N-1:0] meta_q, meta_d;
    lane_meta_t [N-1:0]                  lane_meta;

    logic signed [N-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_rows_q, j_rows_d;
    logic [N-1:0] j_rows_valid_q, j_rows_valid_d;
    logic [N-1:0] sigma_bits_q, sigma_bits_d;

    logic [N-1:0][VECTOR_SIZE-1:0] sel_oh;
    logic [N-1:0]                  sel_found;
    logic [VECTOR_SIZE-1:0]        picked;
    logic                          issue;

    lowest_n_select #(.N(N), .W(VECTOR_SIZE)) u_sel (
        .mask  (rem_mask_q),
        .sel   (sel_oh),
        .found (sel_found)
    );

    // Issue side: lanes beyond the remaining popcount stay idle
    always_comb begin
        issue       = (state_q == SCAN) && !abort;
        picked      = '0;
        mem_rd_en   = '0;
        mem_rd_addr = '0;
        lane_meta   = '0;
        for (int r = 0; r < N; r++) begin
            mem_rd_en[r] = issue && sel_found[r];
            for (int i = 0; i < VECTOR_SIZE; i++)
                if (sel_oh[r][i] && mem_rd_en[r]) mem_rd_addr[r] = IDX_WIDTH'(i);
            lane_meta[r].en    = mem_rd_en[r];
            lane_meta[r].sigma = mem_rd_en[r] && |(sel_oh[r] & sig_reg_q);
            if (mem_rd_en[r]) picked = picked | sel_oh[r];
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_mask_d = rem_mask_q;
        sig_reg_d  = sig_reg_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                rem_mask_d = flip_mask;
                sig_reg_d  = sigma_new;
                cnt_d      = '0;
                state_d    = (|flip_mask) ? SCAN : DRAIN;
            end
            SCAN: begin
                rem_mask_d = rem_mask_q & ~picked;
                if (rem_mask_d == '0) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // MEM_LATENCY+1 counting cycles, then one more cycle carrying done
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MEM_LATENCY))     done_d  = 1'b1;
                if (cnt_q == CW'(MEM_LATENCY + 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            rem_mask_d = '0;
            cnt_d      = '0;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        meta_d[0] = lane_meta;
        for (int k = 1; k < MEM_LATENCY; k++) meta_d[k] = meta_q[k-1];
        if (abort) meta_d = '0;
        j_rows_d       = '0;
        j_rows_valid_d = '0;
        sigma_bits_d   = '0;
        for (int r = 0; r < N; r++) begin
            j_rows_valid_d[r] = meta_q[MEM_LATENCY-1][r].en && !abort;
            sigma_bits_d[r]   = j_rows_valid_d[r] && meta_q[MEM_LATENCY-1][r].sigma;
            if (j_rows_valid_d[r]) j_rows_d[r] = mem_rd_data[r];
        end
    end

`ifdef FLIP_ROW_FEEDER_STATS_EN
    logic [31:0] stat_rows_q, stat_rows_d, stat_steps_q, stat_steps_d;
    logic [32:0] rows_sum;

    always_comb begin
        rows_sum = {1'b0, stat_rows_q};
        for (int r = 0; r < N; r++) rows_sum = rows_sum + 33'(j_rows_valid_q[r]);
        stat_rows_d  = rows_sum[32] ? '1 : rows_sum[31:0];
        stat_steps_d = (done_q && stat_steps_q != '1) ? stat_steps_q + 32'd1 : stat_steps_q;
    end

    assign stat_rows  = stat_rows_q;
    assign stat_steps = stat_steps_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rem_mask_q     <= '0;
            sig_reg_q      <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            meta_q         <= '0;
            j_rows_q       <= '0;
            j_rows_valid_q <= '0;
            sigma_bits_q   <= '0;
`ifdef FLIP_ROW_FEEDER_STATS_EN
            stat_rows_q    <= '0;
            stat_steps_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rem_mask_q     <= rem_mask_d;
            sig_reg_q      <= sig_reg_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            meta_q         <= meta_d;
            j_rows_q       <= j_rows_d;
            j_rows_valid_q <= j_rows_valid_d;
            sigma_bits_q   <= sigma_bits_d;
`ifdef FLIP_ROW_FEEDER_STATS_EN
            stat_rows_q    <= stat_rows_d;
            stat_steps_q   <= stat_steps_d;
`endif
        end
    end

    assign j_rows       = j_rows_q;
    assign j_rows_valid = j_rows_valid_q;
    assign sigma_bits   = sigma_bits_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule
